int_rti_seq: RTL

//  Interrupt-entry / RTI-exit sequencer for the 5-stage pipeline. On interrupt it

---
 rtl/int_rti_seq_pkg.sv | 52 +++++
 rtl/int_rti_seq_sp_reg.sv | 22 ++
 rtl/int_rti_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/int_rti_seq_pkg.sv
// Shared widths, state encoding and stack-frame ordering for the interrupt
// entry / RTI exit sequencer.
package int_rti_seq_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned ADDR_W = 11;

    localparam logic [ADDR_W-1:0] SP_INIT = '1;
    localparam logic [PC_W-1:0]   INT_VEC = '0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PUSH_HI = 4'd1,
        ST_PUSH_LO = 4'd2,
        ST_PUSH_FL = 4'd3,
        ST_VECTOR  = 4'd4,
        ST_POP_FL  = 4'd5,
        ST_POP_LO  = 4'd6,
        ST_POP_HI  = 4'd7,
        ST_RESUME  = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        WORD_HI = 2'd0,
        WORD_LO = 2'd1,
        WORD_FL = 2'd2
    } word_e;

    // Frame order: push HI, LO, FL; pop mirrors it as FL, LO, HI.
    function automatic state_e mem_next(input state_e s);
        case (s)
            ST_PUSH_HI: return ST_PUSH_LO;
            ST_PUSH_LO: return ST_PUSH_FL;
            ST_PUSH_FL: return ST_VECTOR;
            ST_POP_FL:  return ST_POP_LO;
            ST_POP_LO:  return ST_POP_HI;
            ST_POP_HI:  return ST_RESUME;
            default:    return ST_IDLE;
        endcase
    endfunction

    function automatic word_e state_word(input state_e s);
        case (s)
            ST_PUSH_HI, ST_POP_HI: return WORD_HI;
            ST_PUSH_LO, ST_POP_LO: return WORD_LO;
            default:               return WORD_FL;
        endcase
    endfunction

endpackage

// File: rtl/int_rti_seq_sp_reg.sv
// Stack pointer: decrements on push, increments on pop, wraps modulo 2^ADDR_W.
module int_rti_seq_sp_reg
    import int_rti_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] sp
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= SP_INIT;
        end else if (dec) begin
            sp <= sp - ADDR_W'(1);
        end else if (inc) begin
            sp <= sp + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/int_rti_seq.sv
// Interrupt-entry / RTI-exit sequencer: pushes PC and flags to the data-memory
// stack on interrupt, vectors, and pops/restores them on RTI.
module int_rti_seq
    import int_rti_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              rti_dec,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              prev_cs_we,
    output logic              stall_out,
    output logic              flush_out,
    output logic              int_ack,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_out,
    output logic              flags_load,
    output logic [FLAG_W-1:0] flags_out
);

    state_e              state;
    state_e              state_nxt;
    logic [ADDR_W-1:0]   sp;
    logic                sp_inc;
    logic                sp_dec;
    logic                accept_int;
    logic [PC_W-1:0]     saved_pc;
    logic [FLAG_W-1:0]   saved_fl;
    logic [DATA_W-1:0]   push_data;

    int_rti_seq_sp_reg sp_reg (
        .clk (clk),
        .rst (rst),
        .inc (sp_inc),
        .dec (sp_dec),
        .sp  (sp)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        push_data = '0;
        case (state_word(state))
            WORD_HI: push_data = saved_pc[PC_W-1:DATA_W];
            WORD_LO: push_data = saved_pc[DATA_W-1:0];
            default: push_data = DATA_W'(saved_fl);
        endcase
    end

    // Moore outputs per state; only the IDLE acceptance pulses look at int_req.
    always_comb begin
        state_nxt  = state;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        accept_int = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        prev_cs_we = 1'b0;
        stall_out  = 1'b0;
        flush_out  = 1'b0;
        int_ack    = 1'b0;
        pc_load    = 1'b0;
        pc_out     = '0;
        flags_load = 1'b0;
        flags_out  = '0;

        case (state)
            ST_IDLE: begin
                if (int_req) begin
                    accept_int = 1'b1;
                    int_ack    = 1'b1;
                    flush_out  = 1'b1;
                    prev_cs_we = 1'b1;
                    state_nxt  = ST_PUSH_HI;
                end else if (rti_dec) begin
                    state_nxt = ST_POP_FL;
                end
            end
            ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_FL: begin
                stall_out = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = push_data;
                if (mem_ready) begin
                    sp_dec    = 1'b1;
                    state_nxt = mem_next(state);
                end
            end
            ST_POP_FL, ST_POP_LO, ST_POP_HI: begin
                stall_out = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = sp + ADDR_W'(1);
                if (mem_ready) begin
                    sp_inc    = 1'b1;
                    state_nxt = mem_next(state);
                end
            end
            ST_VECTOR: begin
                stall_out  = 1'b1;
                pc_load    = 1'b1;
                pc_out     = INT_VEC;
                flags_load = 1'b1;
                state_nxt  = ST_IDLE;
            end
            ST_RESUME: begin
                stall_out  = 1'b1;
                pc_load    = 1'b1;
                pc_out     = saved_pc;
                flags_load = 1'b1;
                flags_out  = saved_fl;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Saved frame: loaded from the pipeline on entry, rebuilt word by word on pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            saved_pc <= '0;
            saved_fl <= '0;
        end else if (accept_int) begin
            saved_pc <= pc_in;
            saved_fl <= flags_in;
        end else if (sp_inc) begin
            case (state_word(state))
                WORD_HI: saved_pc[PC_W-1:DATA_W] <= mem_rdata;
                WORD_LO: saved_pc[DATA_W-1:0]    <= mem_rdata;
                default: saved_fl                <= mem_rdata[FLAG_W-1:0];
            endcase
        end
    end

endmodule
